// File: rtl/apa102_pkg.sv
// Shared constants and state encoding for the APA102 strip link.
// The receiving end (apa102_in) uses the same frame geometry.
package apa102_pkg;

  localparam int START_BITS        = 32;
  localparam int LED_COUNT         = 7;
  localparam int LED_FRAME_BITS    = 32;
  localparam int COLOUR_FIELD_BITS = 3;

  localparam logic [2:0] HEADER_PREFIX = 3'b111;

  localparam int LED_END_BIT = START_BITS + LED_COUNT * LED_FRAME_BITS;

  typedef enum logic [1:0] {
    IDLE,
    START_F,
    LED_F,
    END_F
  } state_e;

endpackage

// File: rtl/apa102_if.sv
// Frame request and serial strip signals of the APA102 transmitter.
// The master side requests frames; the slave side drives the strip.
interface apa102_if;

  logic        start;
  logic [62:0] data_in;
  logic [4:0]  brightness;
  logic        sck;
  logic        sda;
  logic        busy;
  logic        done;

  modport master (
    output start, data_in, brightness,
    input  sck, sda, busy, done
  );

  modport slave (
    input  start, data_in, brightness,
    output sck, sda, busy, done
  );

endinterface

// File: rtl/apa102_sck_gen.sv
// Serial clock divider: each sck phase lasts CLK_DIV clk cycles, starting low.
// The tick strobes fire on the last cycle of a phase, so the next phase begins after that edge.
module apa102_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic fall_tick_o,
  output logic rise_tick_o,
  output logic sck_o
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          sck_q;
  logic          phaseEnd;

  assign phaseEnd    = en_i && (div_q == DIV_LAST);
  assign rise_tick_o = phaseEnd && !sck_q;
  assign fall_tick_o = phaseEnd && sck_q;
  assign sck_o       = sck_q;

  // Disabling returns sck to its low idle level with a fresh divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else if (phaseEnd) begin
      div_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/apa102_out.sv
// APA102 strip transmitter: snapshots colours and brightness on start, then sends
// a start frame, seven LED frames and END_BITS ones, MSB first.
module apa102_out
  import apa102_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int END_BITS = 33
) (
  input logic      clk,
  input logic      rst_n,
  apa102_if.slave  bus
);

  localparam logic [8:0] LED_FIRST_BIT = 9'(START_BITS);
  localparam logic [8:0] END_FIRST_BIT = 9'(LED_END_BIT);
  localparam logic [8:0] LAST_BIT      = 9'(LED_END_BIT + END_BITS - 1);
  localparam logic [5:0] FIELD_TOP     = 6'(3 * LED_COUNT * COLOUR_FIELD_BITS - 1);
  localparam logic [5:0] FIELD_STEP    = 6'(COLOUR_FIELD_BITS);

  state_e      state_q, state_d;
  logic [8:0]  bit_q, bit_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [1:0]  rep_q, rep_d;
  logic [62:0] data_q, data_d;
  logic [4:0]  bright_q, bright_d;
  logic        sda_q, sda_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fallTick, riseTick, sck;
  logic [7:0]  headerByte;

  apa102_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (busy_q),
    .fall_tick_o (fallTick),
    .rise_tick_o (riseTick),
    .sck_o       (sck)
  );

  // sda for the next bit is computed from the advanced counters so it lands on the
  // same edge that starts the low phase. ptr_q tracks the MSB of the current colour
  // field and rep_q walks v[2],v[1],v[0] repeatedly to replicate it across the byte.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    ptr_d      = ptr_q;
    rep_d      = rep_q;
    data_d     = data_q;
    bright_d   = bright_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    headerByte = {HEADER_PREFIX, bright_q};
    unique case (state_q)
      IDLE: begin
        sda_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          data_d   = bus.data_in;
          bright_d = bus.brightness;
          state_d  = START_F;
          bit_d    = '0;
          ptr_d    = FIELD_TOP;
          rep_d    = '0;
          busy_d   = 1'b1;
        end
      end
      default: begin
        if (fallTick) begin
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sda_d   = 1'b0;
            bit_d   = '0;
            ptr_d   = '0;
            rep_d   = '0;
          end else begin
            bit_d = bit_q + 9'd1;
            rep_d = (bit_d[2:0] == 3'd0 || rep_q == 2'd2) ? 2'd0 : rep_q + 2'd1;
            if (state_q == LED_F && bit_q[4:3] != 2'b00 && bit_q[2:0] == 3'd7)
              ptr_d = ptr_q - FIELD_STEP;
            if (bit_d < LED_FIRST_BIT) begin
              state_d = START_F;
              sda_d   = 1'b0;
            end else if (bit_d < END_FIRST_BIT) begin
              state_d = LED_F;
              sda_d   = (bit_d[4:3] == 2'b00) ? headerByte[3'd7 - bit_d[2:0]]
                                              : data_q[ptr_d - {4'd0, rep_d}];
            end else begin
              state_d = END_F;
              sda_d   = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      ptr_q    <= '0;
      rep_q    <= '0;
      data_q   <= '0;
      bright_q <= '0;
      sda_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      ptr_q    <= ptr_d;
      rep_q    <= rep_d;
      data_q   <= data_d;
      bright_q <= bright_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sck  = sck;
  assign bus.sda  = sda_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  assert property (@(posedge clk) disable iff (!rst_n) riseTick |=> bus.sck);

endmodule

// File: doc/apa102_out.md
Name: apa102_out

Overview:
- Serial APA102-style transmitter. On a start request it snapshots a 63-bit packed colour word plus a 5-bit brightness value, then drives one complete strip frame on sck/sda:
  - a start frame;
  - 7 LED frames;
  - an end frame.
- It is the driving end of the strip link. It feeds the apa102_in receiver, physical LED strips, or both.
- It is used for on-chip loopback and for forwarding received colour data down a chain.

Parameters:
- CLK_DIV, default 2: sck half-period in clk cycles. Legal range is 1..255.
- END_BITS, default 33: number of end-frame '1' bits. The extra bit realigns apa102_in, which consumes 289 sck pulses per frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to send a frame; sampled only while idle
- data_in  input  63  packed colours: LED k, colour byte c (0..2) = data_in[62-9k-3c -: 3]
- brightness  input  5  global brightness for every LED header byte
- sck  output  1  serial clock; idles low
- sda  output  1  serial data; changes only while sck is low
- busy  output  1  high from the cycle after start is accepted until the frame completes
- done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (async, rst_n=0): immediately sck=0, sda=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-frame aborts the frame with no done pulse.
- Handshake:
  - start=1 in IDLE latches data_in and brightness into shadow registers. busy=1 from the next cycle.
  - start while busy is ignored, with no queueing.
  - Inputs may change freely after acceptance.
- Bit timing:
  - Each bit lasts 2*CLK_DIV clk cycles: low phase of CLK_DIV cycles, then high phase of CLK_DIV cycles.
  - sda is updated on the first cycle of the low phase and held through the high phase.
  - Receiver samples on the sck rising edge.
- Bit order is MSB first throughout.
- States:
  - IDLE -> START_F on accepted start.
  - START_F: 32 bits of 0.
  - LED_F: 7 frames of 32 bits, LED 0 first. Each frame is:
    - header byte {3'b111, brightness};
    - then colour bytes c=0,1,2, each formed as {v[2:0], v[2:0], v[2:1]} where v is the 3-bit field. This is bit replication, so 3'b111 gives 8'hFF and 3'b100 gives 8'h92.
  - END_F: END_BITS bits of 1.
  - END_F -> IDLE after the high phase of the final bit.
- Counters:
  - 9-bit frame bit counter, running 0 .. 256+END_BITS-1.
  - Divider counter of width ceil(log2(CLK_DIV))+1; it wraps at CLK_DIV-1.
  - Colour field index is derived from the bit counter. No multiplier is needed: use a running 6-bit field pointer decremented by 3.
- Completion:
  - On the cycle after the final high phase: sck=0, sda=0, busy=0, done=1 for exactly one cycle.
  - start may be accepted in that same done cycle. The next frame's first low phase then begins the following cycle.
- Total sck rising edges per frame = 256+END_BITS (289 by default).
- Frame latency from accepted start to done = (256+END_BITS)*2*CLK_DIV+1 cycles.
- CLK_DIV=1 is legal: sck toggles every cycle.

Decomposition:
- Package apa102_pkg holds:
  - START_BITS=32, LED_COUNT=7, LED_FRAME_BITS=32, COLOUR_FIELD_BITS=3;
  - HEADER_PREFIX=3'b111;
  - the state enum (IDLE, START_F, LED_F, END_F).
- apa102_in is to adopt the same constants.
- One sub-module: apa102_sck_gen, a divider producing phase-start strobes (fall_tick, rise_tick) and the registered sck. It is enabled only while busy.

Test Plan:
- CLK_DIV=2, data_in=0, brightness=5'h1F -> bits 0..31 are 0; each LED frame is 8'hFF,8'h00,8'h00,8'h00; then 33 ones; exactly 289 sck rises; done asserted 1157 cycles after start.
- Bit mapping, data_in=63'h7000_0000_0000_0000, brightness=5'h00 -> LED0 frame is 8'hE0,8'hFF,8'h00,8'h00; all other LED frames are 8'hE0,00,00,00.
- Loopback into apa102_in (same clk, CLK_DIV=2), data_in=63'h2AAA_5555_1234_ABCD -> receiver data_out equals data_in after done.
- Two frames back-to-back, start asserted on the done cycle, second data_in=63'h0F0F_0F0F_0F0F_0F0F -> apa102_in captures the second word correctly, proving realignment with END_BITS=33.
- start pulsed mid-frame with different data_in -> ignored; the transmitted bits still match the first snapshot; a single done pulse.
- rst_n driven low mid-LED_F at bit 100 -> sck, sda and busy are 0 in the same cycle with no done pulse. After release, a new start sends a complete correct frame.
